seq_booth_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 27 ++
 rtl/booth_recoder.sv | 18 +
 rtl/seq_booth_multiplier.sv | 133 +++++++++++++
 tb/tb_seq_booth_multiplier.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier and the
// Booth recoder.
//   state_e       : controller states (IDLE, RUN, DONE)
//   booth_digit_t : recoded Booth digit as {neg, one, two} flags
//   calc_iter     : number of radix-4 digits for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Operands are widened by two bits so the top digit always sees a proper
    // sign (or zero) extension; that gives WIDTH/2 + 1 digits.
    function automatic int calc_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder (purely combinational).
//   win_i   : 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
//   digit_o : recoded digit {neg, one, two}, value in {-2,-1,0,+1,+2}
module booth_recoder
    import mult_pkg::*;
(
    input  logic [2:0]   win_i,
    output booth_digit_t digit_o
);

    always_comb begin
        // 3'b111 is -0: neg is suppressed so a zero digit is always positive
        digit_o.neg = win_i[2] & ~(win_i[1] & win_i[0]);
        digit_o.one = win_i[1] ^ win_i[0];
        digit_o.two = (win_i == 3'b011) | (win_i == 3'b100);
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-4 Booth multiplier, signed or unsigned per transaction.
// One multiply in flight; one Booth digit retired per clock in RUN.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: a zero operand at accept goes straight
// to DONE with a zero product (latency 1 instead of ITER+1).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, is_signed sampled together)
//   a, b                  : WIDTH-bit multiplicand / multiplier
//   is_signed             : 1 = two's-complement operands, 0 = unsigned
//   out_valid / out_ready : result handshake, result held under backpressure
//   result                : 2*WIDTH-bit exact product
//   busy                  : high while in RUN or DONE
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int EXT   = WIDTH + 2;
    localparam int ITER  = calc_iter(WIDTH);
    localparam int CNT_W = $clog2(ITER);
    localparam int PW    = 2 * WIDTH;

    state_e                  state_q, state_d;
    // Only the low 2*WIDTH bits of the product are ever observed, and in
    // two's-complement addition higher bits never feed lower ones, so the
    // shifted multiplicand and accumulator are kept at product width.
    logic signed [PW-1:0]    mcand_q, mcand_d;
    logic signed [PW-1:0]    acc_q, acc_d;
    logic [EXT-1:0]          mplier_q, mplier_d;
    logic                    prev_q, prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    booth_digit_t            digit;
    logic signed [PW-1:0]    pp_mag;
    logic signed [PW-1:0]    pp;

    booth_recoder u_recoder (
        .win_i   ({mplier_q[1:0], prev_q}),
        .digit_o (digit)
    );

`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (a == '0) || (b == '0);
`endif

    always_comb begin
        pp_mag = digit.two ? (mcand_q <<< 1) : (digit.one ? mcand_q : '0);
        pp     = digit.neg ? -pp_mag : pp_mag;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;

        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                    mplier_d = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
                    prev_d   = 1'b0;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(ITER - 1);
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    state_d  = zero_op ? DONE : RUN;
`else
                    state_d  = RUN;
`endif
                end
            end
            RUN: begin
                // Shift-register form: the multiplicand moves up by one digit
                // weight while the multiplier window moves down by two bits.
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q <<< 2;
                mplier_d = mplier_q >> 2;
                prev_d   = mplier_q[1];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (WIDTH=32).
// A queue-based reference model holds the exact product and expected latency
// of the operation in flight; a compare process checks handshake outputs and
// the product on every falling edge. Directed cases add literal expectations.
module tb_seq_booth_multiplier;

    localparam int W    = 32;
    localparam int ITER = W / 2 + 1;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = ITER + 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           is_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        if (s) return 64'(longint'($signed(x)) * longint'($signed(y)));
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Transaction tracker: records accepted operands, retires delivered results
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e.prod    = model(a, b, is_signed);
                e.acc_cyc = cyc;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                e.lat     = (a == '0 || b == '0) ? 0 : ITER;
`else
                e.lat     = ITER;
`endif
                q.push_back(e);
            end
        end
    end

    // Compare process
    bit infl, ev;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_busy",      64'(busy),      64'd0);
            check("rst_in_ready",  64'(in_ready),  64'd1);
            check("rst_result",    result,         64'd0);
        end else begin
            infl = (q.size() > 0);
            ev   = infl && ((cyc - q[0].acc_cyc) >= q[0].lat);
            check("out_valid", 64'(out_valid), 64'(ev));
            check("in_ready",  64'(in_ready),  64'(!infl));
            check("busy",      64'(busy),      64'(infl));
            if (ev) check("result", result, q[0].prod);
        end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input bit chk, input logic [63:0] lit, input int lat_lit,
                      input string nm);
        int n;
        bit got;
        @(negedge clk);
        a = ta; b = tb; is_signed = ts; in_valid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            in_valid = 1'b0;
            got = out_valid;
        end
        if (!got) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
        end else if (chk) begin
            check({nm, "_result"},  result, lit);
            check({nm, "_latency"}, 64'(n), 64'(lat_lit));
        end
        @(posedge clk);
    endtask

    logic [W-1:0]   edge_vals [6];
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] r0;
    int             n;

    initial begin
        edge_vals[0] = 32'h0;        edge_vals[1] = 32'h1;
        edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'h2;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        op(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, ITER + 1, "neg7x6");
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001, ITER + 1, "umax_sq");
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h1, ITER + 1, "sneg1_sq");
        op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, ITER + 1, "smin_sq");
        op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'hC000_0000_8000_0000, ITER + 1, "smin_smax");
        op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 64'h4000_0000_0000_0000, ITER + 1, "u2p31_sq");
        op(32'h0, 32'h1234, 1'b0, 1'b1, 64'h0, ZLAT, "zero_a");
        op(32'h1234, 32'h0, 1'b1, 1'b1, 64'h0, ZLAT, "zero_b");

        // Backpressure: result held, new operands ignored until the handshake
        @(negedge clk);
        a = 32'd1000; b = 32'hFFFF_FFFD; is_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_result", result, 64'hFFFF_FFFF_FFFF_F448);
        r0 = result;
        a = 32'd11; b = 32'd13;
        repeat (10) begin
            @(negedge clk);
            check("bp_stable",   result,          r0);
            check("bp_in_ready", 64'(in_ready),   64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_next_accept", 64'(busy), 64'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_result", result, 64'd143);
        @(posedge clk);

        // Asynchronous reset in the middle of RUN aborts the operation
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_result",    result,         64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        op(32'd3, 32'd5, 1'b1, 1'b1, 64'd15, ITER + 1, "post_rst_3x5");

        // Random operands and modes, biased towards corner values
        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
            op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 64'd0, 0, "rand");
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
